// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and default operand width.
package serial_adder_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle for serial_adder; master issues operands, slave returns the result.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, overflow
  );

endinterface

// File: rtl/FullAddrr.sv
// Combinational 1-bit full-adder cell, zero latency, no flow control.
module FullAddrr (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic sum,
  output logic Cout
);

  assign sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit add/subtract, one bit per clock LSB first; WIDTH cycles from accept to done.
// start is only honoured in IDLE or DONE; requests during RUN are dropped, never queued.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-2:0] part_q, part_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_s;
  logic             fa_c;
  logic             load;
  logic [WIDTH-1:0] part_shift;

  FullAddrr u_fa (
    .A   (opa_q[0]),
    .B   (opb_q[0]),
    .Cin (carry_q),
    .sum (fa_s),
    .Cout(fa_c)
  );

  // New sum bit enters at the MSB; after WIDTH steps bit 0 has walked down to position 0.
  assign part_shift = {fa_s, part_q};

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    part_d  = part_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    load    = 1'b0;

    unique case (state_q)
      IDLE: load = bus.start;
      RUN: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = fa_c;
        part_d  = part_shift[WIDTH-1:1];
        if (cnt_q == LAST) begin
          sum_d   = part_shift;
          cout_d  = fa_c;
          ovf_d   = carry_q ^ fa_c;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        load    = bus.start;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Subtraction is a + ~b + 1, so the inverted operand and forced carry are set up at load.
    if (load) begin
      opa_d   = bus.a;
      opb_d   = bus.sub ? ~bus.b : bus.b;
      carry_d = bus.sub ? 1'b1 : bus.cin;
      cnt_d   = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule
